// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder_if
//  Purpose  : Request/response bundle for the RISC-V instruction encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Purpose  : Two-stage RISC-V field-to-word encoder with address tagging.
//  Revision : 1.0  initial release
// ============================================================================
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    inst_encoder_if.slave   bus,
    input  wire logic       addr_clr,
    output logic [7:0]      err_cnt
);

    localparam logic [2:0]  c_FMT_R = 3'd0;
    localparam logic [2:0]  c_FMT_I = 3'd1;
    localparam logic [2:0]  c_FMT_S = 3'd2;
    localparam logic [2:0]  c_FMT_B = 3'd3;
    localparam logic [2:0]  c_FMT_J = 3'd4;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    logic              r_alive;

    logic              r_s1_valid;
    logic [2:0]        r_s1_fmt;
    logic [6:0]        r_s1_opcode;
    logic [4:0]        r_s1_rd;
    logic [4:0]        r_s1_rs1;
    logic [4:0]        r_s1_rs2;
    logic [2:0]        r_s1_funct3;
    logic [6:0]        r_s1_funct7;
    logic [20:0]       r_s1_imm;
    logic              r_s1_err;

    logic              r_s2_valid;
    logic [31:0]       r_s2_inst;
    logic              r_s2_err;

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_err_cnt;

    logic              w_s2_load;
    logic              w_in_ready;
    logic              w_out_hs;
    logic              w_imm12_ok;
    logic              w_imm21_ok;
    logic              w_in_err;
    logic [31:0]       w_packed;

    // Output register refills when empty or when its word leaves this cycle.
    assign w_s2_load  = !r_s2_valid || bus.out_ready;
    assign w_in_ready = r_alive && (!r_s1_valid || w_s2_load);
    assign w_out_hs   = r_s2_valid && bus.out_ready;

    // Sign-extension test: every bit above the field's sign bit matches it.
    assign w_imm12_ok = (bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1);
    assign w_imm21_ok = ((bus.in_imm[31:20] == '0) || (bus.in_imm[31:20] == '1))
                        && !bus.in_imm[0];

    always_comb begin
        w_in_err = 1'b1;
        case (bus.in_fmt)
            c_FMT_R:                   w_in_err = 1'b0;
            c_FMT_I, c_FMT_S, c_FMT_B: w_in_err = !w_imm12_ok;
            c_FMT_J:                   w_in_err = !w_imm21_ok;
            default:                   w_in_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= '0;
            r_s1_opcode <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_funct3 <= '0;
            r_s1_funct7 <= '0;
            r_s1_imm    <= '0;
            r_s1_err    <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_fmt    <= bus.in_fmt;
                r_s1_opcode <= bus.in_opcode;
                r_s1_rd     <= bus.in_rd;
                r_s1_rs1    <= bus.in_rs1;
                r_s1_rs2    <= bus.in_rs2;
                r_s1_funct3 <= bus.in_funct3;
                r_s1_funct7 <= bus.in_funct7;
                r_s1_imm    <= bus.in_imm[20:0];
                r_s1_err    <= w_in_err;
            end
        end
    end

    // Out-of-range immediates still pack from their low bits.
    always_comb begin
        w_packed = c_NOP;
        case (r_s1_fmt)
            c_FMT_R: w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                 r_s1_rd, r_s1_opcode};
            c_FMT_I: w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3,
                                 r_s1_rd, r_s1_opcode};
            c_FMT_S: w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                 r_s1_imm[4:0], r_s1_opcode};
            c_FMT_B: w_packed = {r_s1_imm[11], r_s1_imm[9:4], r_s1_rs2, r_s1_rs1,
                                 r_s1_funct3, r_s1_imm[3:0], r_s1_imm[10],
                                 r_s1_opcode};
            c_FMT_J: w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                                 r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
            default: w_packed = c_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_inst  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_inst <= w_packed;
                r_s2_err  <= r_s1_err;
            end
        end
    end

    // A clear request overrides the advance of a coincident handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= BASE_ADDR;
        end else if (addr_clr) begin
            r_addr <= BASE_ADDR;
        end else if (w_out_hs) begin
            r_addr <= r_addr + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_out_hs && r_s2_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_inst  = r_s2_inst;
    assign bus.out_err   = r_s2_err;
    assign bus.out_addr  = r_addr;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire
